vending_ctrl_param: RTL and testbench

- Parametrised next-generation vending controller: N products with a per-product price table and per-product stock counters.
- Accepts coin-by-coin credit accumulation and online payment; inactivity timeout triggers automatic refund.
- Change is returned through a valid/ack handshake to the coin-return mechanism.
- Sits between the front-panel/payment inputs and the dispenser and coin-return actuators.

---
 rtl/vending_ctrl_param_if.sv | 46 ++++
 rtl/vending_ctrl_param.sv | 177 +++++++++++++++++
 tb/tb_vending_ctrl_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vending_ctrl_param_if.sv
// Front-panel / actuator bundle for vending_ctrl_param.
// The master drives the panel and payment inputs; the controller is the slave.
interface vending_ctrl_param_if #(
  parameter int unsigned NUM_PRODUCTS = 8,
  parameter int unsigned VAL_W        = 8,
  parameter int unsigned STOCK_W      = 4
);
  localparam int unsigned SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;

  logic               start;
  logic               sel_valid;
  logic [SEL_W-1:0]   product_sel;
  logic               coin_valid;
  logic [VAL_W-1:0]   coin_value;
  logic               online_paid;
  logic               cancel;
  logic               refill_valid;
  logic [SEL_W-1:0]   refill_idx;
  logic [STOCK_W-1:0] refill_qty;
  logic               change_ack;

  logic [2:0]         state;
  logic               busy;
  logic [VAL_W-1:0]   product_price;
  logic [VAL_W-1:0]   credit;
  logic               dispense_valid;
  logic [SEL_W-1:0]   dispense_idx;
  logic               change_valid;
  logic [VAL_W-1:0]   change_amount;
  logic               sold_out;
  logic               err_invalid;

  modport master (
    output start, sel_valid, product_sel, coin_valid, coin_value, online_paid, cancel,
           refill_valid, refill_idx, refill_qty, change_ack,
    input  state, busy, product_price, credit, dispense_valid, dispense_idx,
           change_valid, change_amount, sold_out, err_invalid
  );

  modport slave (
    input  start, sel_valid, product_sel, coin_valid, coin_value, online_paid, cancel,
           refill_valid, refill_idx, refill_qty, change_ack,
    output state, busy, product_price, credit, dispense_valid, dispense_idx,
           change_valid, change_amount, sold_out, err_invalid
  );
endinterface

// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: price table, per-product stock, coin/online payment,
// inactivity auto-refund and valid/ack change return.
module vending_ctrl_param #(
  parameter int unsigned NUM_PRODUCTS = 8,
  parameter int unsigned VAL_W        = 8,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned INIT_STOCK   = 5,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter logic [NUM_PRODUCTS*VAL_W-1:0] PRICE_TABLE =
    {8'd40, 8'd25, 8'd10, 8'd20, 8'd35, 8'd30, 8'd50, 8'd15}
) (
  input logic                clk,
  input logic                rst,
  vending_ctrl_param_if.slave bus
);
  localparam int unsigned SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSelect   = 3'd1,
    StPay      = 3'd2,
    StDispense = 3'd3,
    StChange   = 3'd4
  } state_e;

  state_e             state_q;
  logic [VAL_W-1:0]   credit_q, price_q, change_amount_q;
  logic [SEL_W-1:0]   sel_idx_q, dispense_idx_q;
  logic [TMR_W-1:0]   timer_q;
  logic               paid_online_q, dispense_valid_q, change_valid_q;
  logic               sold_out_q, err_invalid_q;
  logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
  logic [STOCK_W-1:0] stock_d [NUM_PRODUCTS];
  logic [STOCK_W:0]   stock_sum [NUM_PRODUCTS];
  logic [VAL_W-1:0]   price_tab [NUM_PRODUCTS];

  for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_price
    assign price_tab[g] = PRICE_TABLE[g*VAL_W +: VAL_W];
  end

  logic [VAL_W:0]   credit_sum;
  logic [VAL_W-1:0] credit_next, disp_change;
  logic             sel_in_range, pay_done, timeout_hit, refund_now;

  assign credit_sum   = {1'b0, credit_q} + (bus.coin_valid ? {1'b0, bus.coin_value} : '0);
  assign credit_next  = credit_sum[VAL_W] ? '1 : credit_sum[VAL_W-1:0];
  assign sel_in_range = 32'(bus.product_sel) < NUM_PRODUCTS;
  assign pay_done     = bus.online_paid || (credit_next >= price_q);
  assign timeout_hit  = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  // A coin or an online payment counts as activity, so only a quiet cycle can time out.
  assign refund_now   = bus.cancel || (!bus.coin_valid && !bus.online_paid && timeout_hit);
  assign disp_change  = paid_online_q ? credit_q : credit_q - price_q;

  // Refill and dispense on the same product in one cycle both apply before saturation.
  always_comb begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      stock_sum[i] = {1'b0, stock_q[i]}
                   + ((bus.refill_valid && bus.refill_idx == SEL_W'(i)) ?
                      {1'b0, bus.refill_qty} : '0)
                   - (STOCK_W+1)'(state_q == StDispense && sel_idx_q == SEL_W'(i));
      stock_d[i]   = stock_sum[i][STOCK_W] ? '1 : stock_sum[i][STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      stock_q <= stock_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      credit_q         <= '0;
      price_q          <= '0;
      change_amount_q  <= '0;
      sel_idx_q        <= '0;
      dispense_idx_q   <= '0;
      timer_q          <= '0;
      paid_online_q    <= 1'b0;
      dispense_valid_q <= 1'b0;
      change_valid_q   <= 1'b0;
      sold_out_q       <= 1'b0;
      err_invalid_q    <= 1'b0;
    end else begin
      dispense_valid_q <= 1'b0;
      sold_out_q       <= 1'b0;
      err_invalid_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          credit_q <= '0;
          timer_q  <= '0;
          if (bus.start) state_q <= StSelect;
        end
        StSelect: begin
          if (bus.cancel) begin
            state_q <= StIdle;
          end else if (bus.sel_valid) begin
            if (!sel_in_range) begin
              err_invalid_q <= 1'b1;
              state_q       <= StIdle;
            end else if (stock_q[bus.product_sel] == '0) begin
              sold_out_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              sel_idx_q <= bus.product_sel;
              price_q   <= price_tab[bus.product_sel];
              timer_q   <= '0;
              state_q   <= StPay;
            end
          end else if (timeout_hit) begin
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StPay: begin
          credit_q <= credit_next;
          if (refund_now) begin
            price_q <= '0;
            if (credit_next == '0) begin
              credit_q <= '0;
              state_q  <= StIdle;
            end else begin
              change_valid_q  <= 1'b1;
              change_amount_q <= credit_next;
              state_q         <= StChange;
            end
          end else if (pay_done) begin
            paid_online_q    <= bus.online_paid;
            dispense_valid_q <= 1'b1;
            dispense_idx_q   <= sel_idx_q;
            state_q          <= StDispense;
          end else if (bus.coin_valid) begin
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StDispense: begin
          price_q <= '0;
          if (disp_change == '0) begin
            credit_q <= '0;
            state_q  <= StIdle;
          end else begin
            change_valid_q  <= 1'b1;
            change_amount_q <= disp_change;
            state_q         <= StChange;
          end
        end
        StChange: begin
          if (bus.change_ack) begin
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            credit_q        <= '0;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.state          = state_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.product_price  = price_q;
  assign bus.credit         = credit_q;
  assign bus.dispense_valid = dispense_valid_q;
  assign bus.dispense_idx   = dispense_idx_q;
  assign bus.change_valid   = change_valid_q;
  assign bus.change_amount  = change_amount_q;
  assign bus.sold_out       = sold_out_q;
  assign bus.err_invalid    = err_invalid_q;
endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed bench for vending_ctrl_param: 6 products, 6-bit values, 20-cycle timeout.
module tb_vending_ctrl_param;
  localparam int unsigned NP = 6;
  localparam int unsigned VW = 6;
  localparam int unsigned SW = 4;
  // Prices: p0=15 p1=50 p2=30 p3=35 p4=20 p5=10
  localparam logic [NP*VW-1:0] PT = {6'd10, 6'd20, 6'd35, 6'd30, 6'd50, 6'd15};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  vending_ctrl_param_if #(.NUM_PRODUCTS(NP), .VAL_W(VW), .STOCK_W(SW)) vif ();

  vending_ctrl_param #(
    .NUM_PRODUCTS(NP), .VAL_W(VW), .STOCK_W(SW), .INIT_STOCK(5),
    .TIMEOUT_CYC(20), .PRICE_TABLE(PT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vif.start = 0; vif.sel_valid = 0; vif.product_sel = '0; vif.coin_valid = 0;
    vif.coin_value = '0; vif.online_paid = 0; vif.cancel = 0; vif.refill_valid = 0;
    vif.refill_idx = '0; vif.refill_qty = '0; vif.change_ack = 0;
  endtask

  task automatic start_sel(input int idx);
    vif.start = 1; tick(); vif.start = 0;
    vif.sel_valid = 1; vif.product_sel = 3'(idx); tick(); vif.sel_valid = 0;
  endtask

  task automatic coin(input int val);
    vif.coin_valid = 1; vif.coin_value = 6'(val); tick(); vif.coin_valid = 0;
  endtask

  task automatic ack();
    vif.change_ack = 1; tick(); vif.change_ack = 0;
  endtask

  // Exact-price coin purchase: returns to IDLE with no change.
  task automatic buy(input int idx, input int val);
    start_sel(idx); coin(val); tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (vif.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", vif.state); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", vif.busy); end
    checks++; if (vif.credit !== 6'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", vif.credit); end
    checks++; if (vif.change_valid !== 1'b0 || vif.dispense_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: chg=%0b disp=%0b want 0 0", vif.change_valid, vif.dispense_valid); end
    checks++; if (vif.product_price !== 6'd0) begin errors++; $display("FAIL reset_price: got %0d want 0", vif.product_price); end
    #10 rst = 0;
    tick();
  endtask

  task automatic test_coin_purchase();
    vif.start = 1; tick(); vif.start = 0;
    checks++; if (vif.state !== 3'd1 || vif.busy !== 1'b1) begin errors++; $display("FAIL start_select: state=%0d busy=%0b want 1 1", vif.state, vif.busy); end
    vif.sel_valid = 1; vif.product_sel = 3'd3; tick(); vif.sel_valid = 0;
    checks++; if (vif.state !== 3'd2 || vif.product_price !== 6'd35) begin errors++; $display("FAIL sel3_pay: state=%0d price=%0d want 2 35", vif.state, vif.product_price); end
    coin(20); coin(10);
    checks++; if (vif.credit !== 6'd30 || vif.state !== 3'd2) begin errors++; $display("FAIL coin_accum: credit=%0d state=%0d want 30 2", vif.credit, vif.state); end
    coin(10);
    checks++; if (vif.state !== 3'd3 || vif.dispense_valid !== 1'b1 || vif.dispense_idx !== 3'd3) begin errors++; $display("FAIL coin_dispense: state=%0d dv=%0b idx=%0d want 3 1 3", vif.state, vif.dispense_valid, vif.dispense_idx); end
    tick();
    checks++; if (vif.state !== 3'd4 || vif.change_valid !== 1'b1 || vif.change_amount !== 6'd5 || vif.dispense_valid !== 1'b0) begin errors++; $display("FAIL coin_change: state=%0d cv=%0b amt=%0d dv=%0b want 4 1 5 0", vif.state, vif.change_valid, vif.change_amount, vif.dispense_valid); end
    tick();
    checks++; if (vif.change_valid !== 1'b1 || vif.change_amount !== 6'd5) begin errors++; $display("FAIL change_hold: cv=%0b amt=%0d want 1 5", vif.change_valid, vif.change_amount); end
    ack();
    checks++; if (vif.state !== 3'd0 || vif.change_valid !== 1'b0 || vif.credit !== 6'd0) begin errors++; $display("FAIL ack_idle: state=%0d cv=%0b credit=%0d want 0 0 0", vif.state, vif.change_valid, vif.credit); end
  endtask

  task automatic test_online();
    start_sel(1); coin(10);
    vif.online_paid = 1; tick(); vif.online_paid = 0;
    checks++; if (vif.state !== 3'd3 || vif.dispense_idx !== 3'd1) begin errors++; $display("FAIL online_dispense: state=%0d idx=%0d want 3 1", vif.state, vif.dispense_idx); end
    tick();
    checks++; if (vif.change_valid !== 1'b1 || vif.change_amount !== 6'd10) begin errors++; $display("FAIL online_refund: cv=%0b amt=%0d want 1 10", vif.change_valid, vif.change_amount); end
    ack();
    start_sel(4);
    vif.online_paid = 1; tick(); vif.online_paid = 0;
    checks++; if (vif.dispense_valid !== 1'b1 || vif.dispense_idx !== 3'd4) begin errors++; $display("FAIL online_nocoin_disp: dv=%0b idx=%0d want 1 4", vif.dispense_valid, vif.dispense_idx); end
    tick();
    checks++; if (vif.state !== 3'd0 || vif.change_valid !== 1'b0) begin errors++; $display("FAIL online_nocoin_idle: state=%0d cv=%0b want 0 0", vif.state, vif.change_valid); end
  endtask

  task automatic test_cancel();
    start_sel(2); coin(10);
    vif.cancel = 1; vif.coin_valid = 1; vif.coin_value = 6'd5; tick();
    vif.cancel = 0; vif.coin_valid = 0;
    checks++; if (vif.state !== 3'd4 || vif.change_amount !== 6'd15 || vif.dispense_valid !== 1'b0) begin errors++; $display("FAIL cancel_refund: state=%0d amt=%0d dv=%0b want 4 15 0", vif.state, vif.change_amount, vif.dispense_valid); end
    ack();
    vif.start = 1; tick(); vif.start = 0;
    vif.cancel = 1; tick(); vif.cancel = 0;
    checks++; if (vif.state !== 3'd0 || vif.change_valid !== 1'b0) begin errors++; $display("FAIL cancel_select: state=%0d cv=%0b want 0 0", vif.state, vif.change_valid); end
  endtask

  task automatic test_sold_out();
    repeat (5) buy(0, 15);
    start_sel(0);
    checks++; if (vif.sold_out !== 1'b1 || vif.state !== 3'd0) begin errors++; $display("FAIL sold_out: so=%0b state=%0d want 1 0", vif.sold_out, vif.state); end
    tick();
    checks++; if (vif.sold_out !== 1'b0) begin errors++; $display("FAIL sold_out_pulse: so=%0b want 0", vif.sold_out); end
    start_sel(7);
    checks++; if (vif.err_invalid !== 1'b1 || vif.state !== 3'd0) begin errors++; $display("FAIL err_invalid: err=%0b state=%0d want 1 0", vif.err_invalid, vif.state); end
    vif.refill_valid = 1; vif.refill_idx = 3'd0; vif.refill_qty = 4'd3; tick(); vif.refill_valid = 0;
    start_sel(0);
    checks++; if (vif.state !== 3'd2) begin errors++; $display("FAIL refill_select: state=%0d want 2", vif.state); end
    coin(15);
    checks++; if (vif.dispense_valid !== 1'b1 || vif.dispense_idx !== 3'd0) begin errors++; $display("FAIL refill_dispense: dv=%0b idx=%0d want 1 0", vif.dispense_valid, vif.dispense_idx); end
    tick();
  endtask

  task automatic test_timeout();
    vif.start = 1; tick(); vif.start = 0;
    repeat (19) tick();
    checks++; if (vif.state !== 3'd1) begin errors++; $display("FAIL select_pre_timeout: state=%0d want 1", vif.state); end
    tick();
    checks++; if (vif.state !== 3'd0) begin errors++; $display("FAIL select_timeout: state=%0d want 0", vif.state); end
    start_sel(4); coin(10);
    repeat (14) tick();
    coin(5);
    repeat (19) tick();
    checks++; if (vif.state !== 3'd2 || vif.credit !== 6'd15) begin errors++; $display("FAIL pay_pre_timeout: state=%0d credit=%0d want 2 15", vif.state, vif.credit); end
    tick();
    checks++; if (vif.state !== 3'd4 || vif.change_amount !== 6'd15) begin errors++; $display("FAIL pay_timeout: state=%0d amt=%0d want 4 15", vif.state, vif.change_amount); end
    ack();
  endtask

  task automatic test_saturation();
    start_sel(1); coin(40);
    checks++; if (vif.credit !== 6'd40) begin errors++; $display("FAIL sat_first: credit=%0d want 40", vif.credit); end
    coin(40);
    checks++; if (vif.credit !== 6'd63 || vif.state !== 3'd3) begin errors++; $display("FAIL sat_credit: credit=%0d state=%0d want 63 3", vif.credit, vif.state); end
    tick();
    checks++; if (vif.change_amount !== 6'd13) begin errors++; $display("FAIL sat_change: amt=%0d want 13", vif.change_amount); end
    ack();
    vif.refill_valid = 1; vif.refill_idx = 3'd5; vif.refill_qty = 4'd15; tick(); vif.refill_valid = 0;
    repeat (14) buy(5, 10);
    start_sel(5); coin(10);
    checks++; if (vif.dispense_valid !== 1'b1) begin errors++; $display("FAIL stock_sat_15th: dv=%0b want 1", vif.dispense_valid); end
    tick();
    start_sel(5);
    checks++; if (vif.sold_out !== 1'b1) begin errors++; $display("FAIL stock_sat_16th: so=%0b want 1", vif.sold_out); end
  endtask

  task automatic test_reset_mid();
    start_sel(2); coin(10);
    checks++; if (vif.credit !== 6'd10) begin errors++; $display("FAIL mid_credit: credit=%0d want 10", vif.credit); end
    #2 rst = 1;
    #1;
    checks++; if (vif.state !== 3'd0 || vif.busy !== 1'b0 || vif.credit !== 6'd0 || vif.product_price !== 6'd0 || vif.change_valid !== 1'b0) begin errors++; $display("FAIL async_reset: state=%0d busy=%0b credit=%0d price=%0d cv=%0b want 0", vif.state, vif.busy, vif.credit, vif.product_price, vif.change_valid); end
    #2 rst = 0;
    tick();
    repeat (4) buy(0, 15);
    start_sel(0); coin(15);
    checks++; if (vif.dispense_valid !== 1'b1) begin errors++; $display("FAIL reset_stock_5th: dv=%0b want 1", vif.dispense_valid); end
    tick();
    start_sel(0);
    checks++; if (vif.sold_out !== 1'b1) begin errors++; $display("FAIL reset_stock_6th: so=%0b want 1", vif.sold_out); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_coin_purchase();
    test_online();
    test_cancel();
    test_sold_out();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
